// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED pattern scheduler: display modes,
// bounce direction and the pattern each mode starts from.
package led_sched_pkg;

  localparam int LED_W   = 8;
  localparam int SPEED_W = 2;

  typedef enum logic [1:0] {
    RUN_L  = 2'd0,
    RUN_R  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [LED_W-1:0] PAT_INIT_RUN_L  = 8'h01;
  localparam logic [LED_W-1:0] PAT_INIT_RUN_R  = 8'h80;
  localparam logic [LED_W-1:0] PAT_INIT_BOUNCE = 8'h01;
  localparam logic [LED_W-1:0] PAT_INIT_BLINK  = 8'hFF;

  localparam logic [LED_W-1:0] PAT_LSB = 8'h01;
  localparam logic [LED_W-1:0] PAT_MSB = 8'h80;

  function automatic logic [LED_W-1:0] initPattern(input mode_e mode);
    logic [LED_W-1:0] pat;
    case (mode)
      RUN_L:   pat = PAT_INIT_RUN_L;
      RUN_R:   pat = PAT_INIT_RUN_R;
      BOUNCE:  pat = PAT_INIT_BOUNCE;
      BLINK:   pat = PAT_INIT_BLINK;
      default: pat = PAT_INIT_RUN_L;
    endcase
    return pat;
  endfunction

  function automatic mode_e nextMode(input mode_e mode);
    mode_e nxt;
    case (mode)
      RUN_L:   nxt = RUN_R;
      RUN_R:   nxt = BOUNCE;
      BOUNCE:  nxt = BLINK;
      BLINK:   nxt = RUN_L;
      default: nxt = RUN_L;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-level debounce
// counter and a one-cycle pulse on each accepted press (release is silent).
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; the last disagreeing cycle flips the level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_pattern_scheduler.sv
// Eight-LED pattern sequencer: mode and speed buttons select one of four
// animations stepped by a programmable tick divider; LEDs are driven active-low.
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_DIV     = 10_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iBtnMode,
  input  logic               iBtnSpeed,
  output logic [LED_W-1:0]   oLED,
  output logic [1:0]         oMode,
  output logic [SPEED_W-1:0] oSpeed,
  output logic               oTick
);

  if (TICK_DIV < 16 || (TICK_DIV % 8) != 0 || TICK_DIV > CLK_HZ) begin : gBadTickDiv
    $error("led_pattern_scheduler: TICK_DIV must be >= 16, a multiple of 8 and <= CLK_HZ");
  end
  if (DEBOUNCE_CYC < 2 || DEBOUNCE_CYC > CLK_HZ) begin : gBadDebounce
    $error("led_pattern_scheduler: DEBOUNCE_CYC must be >= 2 and <= CLK_HZ");
  end

  localparam int TICK_W = $clog2(TICK_DIV);

  logic modePress;
  logic speedPress;
  logic anyPress;
  logic tickHit;

  mode_e              mode_q;
  mode_e              mode_d;
  dir_e               dir_q;
  dir_e               dir_d;
  logic [SPEED_W-1:0] speed_q;
  logic [SPEED_W-1:0] speed_d;
  logic [TICK_W-1:0]  tickCnt_q;
  logic [TICK_W-1:0]  tickCnt_d;
  logic [TICK_W-1:0]  periodLast;
  logic [LED_W-1:0]   pat_q;
  logic [LED_W-1:0]   pat_d;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) uModeBtn (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_i  (iBtnMode),
    .press_o(modePress)
  );

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) uSpeedBtn (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_i  (iBtnSpeed),
    .press_o(speedPress)
  );

  assign anyPress = modePress | speedPress;

  // Each speed step halves the period; any press restarts the count so the
  // next step is always a full period after the press.
  always_comb begin
    periodLast = TICK_W'((TICK_DIV >> speed_q) - 1);
    tickHit    = (tickCnt_q == periodLast);
    tickCnt_d  = tickCnt_q + 1'b1;
    if (anyPress || tickHit) begin
      tickCnt_d = '0;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    if (modePress) begin
      mode_d = nextMode(mode_q);
    end
    if (speedPress) begin
      speed_d = speed_q + 1'b1;
    end
  end

  // A press in the same cycle as a tick suppresses that step.
  always_comb begin
    pat_d = pat_q;
    dir_d = dir_q;
    if (modePress) begin
      pat_d = initPattern(mode_d);
      dir_d = DIR_LEFT;
    end else if (tickHit && !speedPress) begin
      case (mode_q)
        RUN_L: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        RUN_R: pat_d = {pat_q[0], pat_q[LED_W-1:1]};
        BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            if (pat_q == PAT_MSB) begin
              pat_d = PAT_MSB >> 1;
              dir_d = DIR_RIGHT;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q == PAT_LSB) begin
              pat_d = PAT_LSB << 1;
              dir_d = DIR_LEFT;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        BLINK:   pat_d = ~pat_q;
        default: pat_d = pat_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= RUN_L;
      dir_q     <= DIR_LEFT;
      speed_q   <= '0;
      tickCnt_q <= '0;
      pat_q     <= PAT_INIT_RUN_L;
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      speed_q   <= speed_d;
      tickCnt_q <= tickCnt_d;
      pat_q     <= pat_d;
    end
  end

  assign oLED   = ~pat_q;
  assign oMode  = mode_q;
  assign oSpeed = speed_q;
  assign oTick  = tickHit;

endmodule
